// File: rtl/ltc2666_spi_if.sv
`default_nettype none
// ============================================================================
// Module   : ltc2666_spi_if
// Desc     : Shared SPI bus to a chain of LTC2666 DACs (common SCK/SDI/SDO,
//            one active-low chip select per device).
// Revision : 1.0 - initial release
// ============================================================================
interface ltc2666_spi_if #(
    parameter int NCHIP = 2
);
    logic             sck;
    logic             sdi;
    logic             sdo;
    logic [NCHIP-1:0] cs_n;

    modport master (output sck, output sdi, output cs_n, input sdo);
    modport slave  (input sck, input sdi, input cs_n, output sdo);
endinterface
`default_nettype wire

// File: rtl/ltc2666_chain_seq.sv
`default_nettype none
// ============================================================================
// Module   : ltc2666_chain_seq
// Desc     : Sequenced writer for NCHIP LTC2666-16 DACs with offset/saturation
//            and per-chip SDO echo checking.
// Revision : 1.0 - initial release
// ============================================================================
module ltc2666_chain_seq #(
    parameter int NCHIP  = 2,
    parameter int NSEQ   = 24,
    parameter int CLKDIV = 2,
    parameter int CSGAP  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [3*NCHIP*NSEQ-1:0] ch_seq,
    input  logic [16*8*NCHIP-1:0]   din,
    input  logic [16*8*NCHIP-1:0]   offs,
    ltc2666_spi_if.master           spi,
    output logic                    busy,
    output logic                    frame_done,
    output logic                    echo_err
);

    localparam int CW      = (NCHIP > 1) ? $clog2(NCHIP) : 1;
    localparam int SW      = (NSEQ > 1) ? $clog2(NSEQ) : 1;
    localparam int CNT_MAX = (2*CLKDIV > CSGAP) ? 2*CLKDIV : CSGAP;
    localparam int CNTW    = $clog2(CNT_MAX + 1);

    localparam logic [CNTW-1:0] DIV_LAST = CNTW'(CLKDIV - 1);
    localparam logic [CNTW-1:0] PER_LAST = CNTW'(2*CLKDIV - 1);
    localparam logic [CNTW-1:0] GAP_LAST = CNTW'(CSGAP - 1);
    localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);
    localparam logic [CW-1:0]   C_LAST   = CW'(NCHIP - 1);
    localparam logic [SW-1:0]   S_LAST   = SW'(NSEQ - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SETUP = 3'd2,
        ST_SHIFT = 3'd3,
        ST_HOLD  = 3'd4,
        ST_GAP   = 3'd5
    } state_t;

    state_t                  state_q, state_d;
    logic [CNTW-1:0]         cnt_q, cnt_d;
    logic [4:0]              bit_q, bit_d;
    logic [SW-1:0]           s_q, s_d;
    logic [CW-1:0]           c_q, c_d;
    logic [23:0]             word_q, word_d;
    logic [23:0]             tx_q, tx_d;
    logic [23:0]             rx_q, rx_d;
    logic [NCHIP-1:0][23:0]  prev_q, prev_d;
    logic [NCHIP-1:0]        pval_q, pval_d;
    logic                    err_q, err_d;
    logic                    sck_q, sck_d;
    logic                    sdi_q, sdi_d;
    logic [NCHIP-1:0]        cs_n_q, cs_n_d;
    logic                    fd_q, fd_d;

    logic [2:0]              w_ch;
    logic [15:0]             w_v;
    logic [15:0]             w_o;
    logic signed [17:0]      w_t;
    logic [15:0]             w_sat;
    logic [23:0]             w_word;

    // Two bits of headroom keep v +/- offs exact over the full offset range.
    always_comb begin
        w_ch = ch_seq[3*(int'(c_q)*NSEQ + int'(s_q)) +: 3];
        w_v  = din[16*(8*int'(c_q) + int'(w_ch)) +: 16];
        w_o  = offs[16*(8*int'(c_q) + int'(w_ch)) +: 16];
        if (w_v[15]) begin
            w_t = $signed({{2{w_v[15]}}, w_v} - {2'b00, w_o});
        end else begin
            w_t = $signed({2'b00, w_v} + {2'b00, w_o});
        end
        if (w_t > 18'sd32767) begin
            w_sat = 16'h7FFF;
        end else if (w_t < -18'sd32768) begin
            w_sat = 16'h8000;
        end else begin
            w_sat = w_t[15:0];
        end
        w_word = {4'b0011, 1'b0, w_ch, ~w_sat[15], w_sat[14:0]};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        s_d     = s_q;
        c_d     = c_q;
        word_d  = word_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        prev_d  = prev_q;
        pval_d  = pval_q;
        err_d   = err_q;
        sdi_d   = sdi_q;
        fd_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (en) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                word_d  = w_word;
                tx_d    = w_word;
                sdi_d   = w_word[23];
                rx_d    = '0;
                cnt_d   = '0;
                bit_d   = '0;
                state_d = ST_SETUP;
            end
            ST_SETUP: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_SHIFT: begin
                // First half of each period is sck low; rise samples sdo, fall shifts sdi.
                if (cnt_q == DIV_LAST) rx_d = {rx_q[22:0], spi.sdo};
                if (cnt_q == PER_LAST) begin
                    cnt_d = '0;
                    tx_d  = {tx_q[22:0], 1'b0};
                    sdi_d = tx_q[22];
                    if (bit_q == 5'd23) begin
                        state_d = ST_HOLD;
                    end else begin
                        bit_d = bit_q + 5'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_HOLD: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_GAP;
                    if (pval_q[c_q] && (rx_q != prev_q[c_q])) err_d = 1'b1;
                    prev_d[c_q] = word_q;
                    pval_d[c_q] = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d = '0;
                    if (c_q == C_LAST) begin
                        c_d = '0;
                        if (s_q == S_LAST) begin
                            s_d  = '0;
                            fd_d = 1'b1;
                        end else begin
                            s_d = s_q + SW'(1);
                        end
                    end else begin
                        c_d = c_q + CW'(1);
                    end
                    state_d = en ? ST_LOAD : ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        sck_d  = (state_d == ST_SHIFT) && (cnt_d > DIV_LAST);
        cs_n_d = '1;
        if (state_d inside {ST_SETUP, ST_SHIFT, ST_HOLD}) cs_n_d[c_q] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            s_q     <= '0;
            c_q     <= '0;
            word_q  <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            prev_q  <= '0;
            pval_q  <= '0;
            err_q   <= 1'b0;
            sck_q   <= 1'b0;
            sdi_q   <= 1'b0;
            cs_n_q  <= '1;
            fd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            s_q     <= s_d;
            c_q     <= c_d;
            word_q  <= word_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            prev_q  <= prev_d;
            pval_q  <= pval_d;
            err_q   <= err_d;
            sck_q   <= sck_d;
            sdi_q   <= sdi_d;
            cs_n_q  <= cs_n_d;
            fd_q    <= fd_d;
        end
    end

    assign spi.sck    = sck_q;
    assign spi.sdi    = sdi_q;
    assign spi.cs_n   = cs_n_q;
    assign busy       = (state_q != ST_IDLE);
    assign frame_done = fd_q;
    assign echo_err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_ltc2666_chain_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_ltc2666_chain_seq
// Desc     : Directed self-checking bench: two DUTs (CLKDIV=1 and CLKDIV=3),
//            per-chip SDO echo model, hand-computed expected words.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ltc2666_chain_seq;

    localparam int NCHIP = 2;
    localparam int NSEQ  = 2;
    localparam int CSGAP = 4;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    en;
    logic [3*NCHIP*NSEQ-1:0] ch_seq;
    logic [16*8*NCHIP-1:0]   din;
    logic [16*8*NCHIP-1:0]   offs;
    logic                    busy1, fd1, err1;
    logic                    busy3, fd3, err3;

    ltc2666_spi_if #(.NCHIP(NCHIP)) spi1 ();
    ltc2666_spi_if #(.NCHIP(NCHIP)) spi3 ();

    ltc2666_chain_seq #(.NCHIP(NCHIP), .NSEQ(NSEQ), .CLKDIV(1), .CSGAP(CSGAP)) u_dut1 (
        .clk(clk), .rst(rst), .en(en), .ch_seq(ch_seq), .din(din), .offs(offs),
        .spi(spi1), .busy(busy1), .frame_done(fd1), .echo_err(err1)
    );

    ltc2666_chain_seq #(.NCHIP(NCHIP), .NSEQ(NSEQ), .CLKDIV(3), .CSGAP(CSGAP)) u_dut3 (
        .clk(clk), .rst(rst), .en(en), .ch_seq(ch_seq), .din(din), .offs(offs),
        .spi(spi3), .busy(busy3), .frame_done(fd3), .echo_err(err3)
    );

    assign spi3.sdo = 1'b0;

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Order: pos0 chip0 ch3, pos1 chip1 ch0, pos2 chip0 ch5, pos3 chip1 ch7
    function automatic logic [23:0] exp_word(input int p, input bit sat);
        logic [23:0] w;
        case (p)
            0:       w = sat ? 24'h33FFFF : 24'h338000;
            1:       w = sat ? 24'h300000 : 24'h308000;
            2:       w = sat ? 24'h357FFE : 24'h358000;
            default: w = sat ? 24'h379334 : 24'h378000;
        endcase
        return w;
    endfunction

    bit               sat_mode;
    int               corrupt_req, corrupt_done;
    int               words, pos, fd_cnt, low_cnt, high_cnt, nbits, multi_cs, sdi_bad, cur_chip;
    logic [23:0]      rxw, sh;
    logic [23:0]      mprev [NCHIP];
    logic [NCHIP-1:0] cs_prev;
    logic             sck_prev, sdi_prev, fd_prev, idle_seen;

    // CLKDIV=1 monitor: word capture, scoreboard and SDO echo model
    always @(negedge clk) begin
        if (rst) begin
            cs_prev   = '1;
            sck_prev  = 1'b0;
            sdi_prev  = 1'b0;
            fd_prev   = 1'b0;
            idle_seen = 1'b1;
            pos       = 0;
            nbits     = 0;
            for (int i = 0; i < NCHIP; i++) mprev[i] = 24'h5A5A5A ^ 24'(i + 1);
            spi1.sdo  = 1'b0;
        end else begin
            if ($countones(~spi1.cs_n) > 1) multi_cs++;
            if (fd1) begin
                fd_cnt++;
                check("fd_after_frame_pos", pos, 0);
                check("fd_width", {31'd0, fd_prev}, 0);
            end
            if (spi1.cs_n != '1) begin
                if (cs_prev == '1) begin
                    cur_chip = spi1.cs_n[0] ? 1 : 0;
                    if (!idle_seen) check("cs_high_gap", high_cnt, CSGAP + 1);
                    sh = mprev[cur_chip];
                    if (corrupt_req != corrupt_done) begin
                        sh[10]       = ~sh[10];
                        corrupt_done = corrupt_req;
                    end
                    spi1.sdo = sh[23];
                    nbits    = 0;
                    rxw      = '0;
                    low_cnt  = 0;
                end else if ((spi1.sdi != sdi_prev) && !(sck_prev && !spi1.sck)) begin
                    sdi_bad++;
                end
                low_cnt++;
                if (spi1.sck && !sck_prev) begin
                    rxw = {rxw[22:0], spi1.sdi};
                    nbits++;
                end
                if (!spi1.sck && sck_prev) begin
                    sh       = {sh[22:0], 1'b0};
                    spi1.sdo = sh[23];
                end
            end else begin
                if (cs_prev != '1) begin
                    check("cs_low_cycles", low_cnt, 50);
                    check("bits_per_word", nbits, 24);
                    check("word_chip", cur_chip, pos % 2);
                    check("word_value", {8'd0, rxw}, {8'd0, exp_word(pos, sat_mode)});
                    mprev[cur_chip] = rxw;
                    words++;
                    pos       = (pos + 1) % 4;
                    high_cnt  = 0;
                    idle_seen = 1'b0;
                end
                high_cnt++;
                if (!busy1) idle_seen = 1'b1;
            end
            cs_prev  = spi1.cs_n;
            sck_prev = spi1.sck;
            sdi_prev = spi1.sdi;
            fd_prev  = fd1;
        end
    end

    int   w3, low3, rises3, since_rise3, sdi_age3, d3_bad;
    logic low3_prev, sck3_prev, sdi3_prev;

    // CLKDIV=3 monitor: SCK period/duty, CS width and SDI stability around rises
    always @(negedge clk) begin
        if (rst) begin
            low3_prev = 1'b0;
            sck3_prev = 1'b0;
            sdi3_prev = 1'b0;
        end else begin
            if (spi3.cs_n != '1) begin
                if (!low3_prev) begin
                    low3     = 0;
                    rises3   = 0;
                    sdi_age3 = 0;
                    since_rise3 = 0;
                end else begin
                    sdi_age3++;
                    since_rise3++;
                    if (spi3.sdi != sdi3_prev) begin
                        if (rises3 > 0 && since_rise3 < 3) d3_bad++;
                        sdi_age3 = 0;
                    end
                end
                low3++;
                if (spi3.sck && !sck3_prev) begin
                    if (rises3 > 0 && since_rise3 != 6) d3_bad++;
                    if (sdi_age3 < 3) d3_bad++;
                    rises3++;
                    since_rise3 = 0;
                end
                if (!spi3.sck && sck3_prev && since_rise3 != 3) d3_bad++;
                low3_prev = 1'b1;
            end else begin
                if (low3_prev) begin
                    check("d3_cs_low_cycles", low3, 150);
                    check("d3_sck_rises", rises3, 24);
                    w3++;
                end
                low3_prev = 1'b0;
            end
            sck3_prev = spi3.sck;
            sdi3_prev = spi3.sdi;
        end
    end

    task automatic wait_words(input int n);
        int k;
        k = 0;
        while (words < n && k < 3000) begin
            @(negedge clk);
            k++;
        end
        if (words < n) check("timeout_words", words, n);
    endtask

    task automatic wait_cs_low();
        int k;
        k = 0;
        while (spi1.cs_n == '1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (spi1.cs_n == '1) check("timeout_cs_low", {30'd0, spi1.cs_n}, 0);
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (busy1) check("timeout_idle", {31'd0, busy1}, 0);
    endtask

    task automatic wait_sck_high();
        int k;
        k = 0;
        while (!spi1.sck && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (!spi1.sck) check("timeout_sck", {31'd0, spi1.sck}, 1);
    endtask

    int base;

    initial begin
        rst          = 1'b1;
        en           = 1'b0;
        ch_seq       = {3'd7, 3'd0, 3'd5, 3'd3};
        din          = '0;
        offs         = '0;
        sat_mode     = 1'b0;
        corrupt_req  = 0;
        corrupt_done = 0;
        repeat (3) @(negedge clk);
        check("rst_cs_n",       {30'd0, spi1.cs_n}, 32'h3);
        check("rst_sck",        {31'd0, spi1.sck}, 0);
        check("rst_sdi",        {31'd0, spi1.sdi}, 0);
        check("rst_busy",       {31'd0, busy1}, 0);
        check("rst_frame_done", {31'd0, fd1}, 0);
        check("rst_echo_err",   {31'd0, err1}, 0);
        check("rst_d3_idle",    {29'd0, busy3, fd3, err3}, 0);

        rst = 1'b0;
        en  = 1'b1;
        wait_words(1);
        wait_cs_low();
        en = 1'b0;
        wait_idle();
        check("stop_after_word2", words, 2);
        repeat (30) @(negedge clk);
        check("idle_hold_words", words, 2);
        check("idle_hold_cs_n", {30'd0, spi1.cs_n}, 32'h3);

        en = 1'b1;
        wait_words(4);
        repeat (10) @(negedge clk);
        check("frame1_done_count", fd_cnt, 1);

        wait_cs_low();
        en = 1'b0;
        wait_idle();
        check("stop_after_word5", words, 5);

        din[16*3  +: 16] = 16'h7FF0;  offs[16*3  +: 16] = 16'h0020;
        din[16*8  +: 16] = 16'h8010;  offs[16*8  +: 16] = 16'h0020;
        din[16*5  +: 16] = 16'hFFFF;  offs[16*5  +: 16] = 16'h0001;
        din[16*15 +: 16] = 16'h1234;  offs[16*15 +: 16] = 16'h0100;
        sat_mode = 1'b1;
        en       = 1'b1;

        wait_words(12);
        repeat (10) @(negedge clk);
        check("echo_clean_3_frames", {31'd0, err1}, 0);
        check("frame3_done_count", fd_cnt, 3);

        corrupt_req++;
        base = words;
        wait_words(base + 2);
        repeat (3) @(negedge clk);
        check("echo_err_on_corrupt", {31'd0, err1}, 1);
        wait_words(base + 4);
        check("echo_err_sticky", {31'd0, err1}, 1);

        wait_cs_low();
        wait_sck_high();
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midword_rst_cs_n", {30'd0, spi1.cs_n}, 32'h3);
        check("midword_rst_sck", {31'd0, spi1.sck}, 0);
        check("midword_rst_echo_err", {31'd0, err1}, 0);
        check("midword_rst_busy", {31'd0, busy1}, 0);
        check("midword_rst_d3_cs_n", {30'd0, spi3.cs_n}, 32'h3);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        base = words;
        wait_words(base + 2);
        repeat (3) @(negedge clk);
        check("no_echo_chk_first_words", {31'd0, err1}, 0);
        wait_words(base + 4);
        repeat (3) @(negedge clk);
        check("echo_clean_after_rst", {31'd0, err1}, 0);

        check("single_cs_low", multi_cs, 0);
        check("sdi_only_on_sck_fall", sdi_bad, 0);
        check("d3_timing_violations", d3_bad, 0);
        check("d3_words_seen", {31'd0, (w3 >= 3)}, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
